// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and SPI framing constants
// Used by spi_burst_master and spi_clk_gen.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_DATA,
        ST_HOLD,
        ST_DONE
    } spi_state_t;

    // Command byte layout: {rw, mb, addr[5:0]}
    localparam int CMD_RW = 7;
    localparam int CMD_MB = 6;

    // Mode 3: SCLK idles high, data changes on falling edge, sampled on rising edge
    localparam logic SPI_CPOL  = 1'b1;
    localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK divider with rise/fall slot ticks
// Ports:
//   clk, reset      system clock, async active-low reset
//   en              count while the master is between IDLE and DONE
//   allow_fall      permit SCLK to drop on the next fall tick
//   sclk            SPI clock, idles high
//   rise_tick       this clock drives SCLK rising (sample point)
//   fall_tick       slot boundary where SCLK would fall (shift point)
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic allow_fall,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             wrap;

    always_comb begin
        wrap      = en && (div_q == DIV_LAST);
        rise_tick = wrap && !sclk_q;
        fall_tick = wrap && sclk_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        if (!en) begin
            div_d  = '0;
            sclk_d = SPI_CPOL;
        end else begin
            div_d = wrap ? '0 : div_q + 1'b1;
            // Fall ticks still pace SETUP/HOLD even when SCLK is held high
            if (rise_tick || (fall_tick && allow_fall)) begin
                sclk_d = ~sclk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            sclk_q <= SPI_CPOL;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_burst_master.sv
// rtl/spi_burst_master.sv - mode-3 SPI master: command byte then burst read or single write
// Ports:
//   clk, reset                         system clock, async active-low reset
//   start, rw, start_addr, num_bytes,  request (sampled in IDLE only)
//   wr_data
//   buffer                             read data, byte k at [8k+7:8k]
//   done, busy                         completion pulse, transaction in progress
//   spi_cs_n, spi_sclk, spi_mosi,      SPI bus
//   spi_miso
module spi_burst_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 6,
    parameter int ADDR_W    = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           rw,
    input  logic [ADDR_W-1:0]              start_addr,
    input  logic [$clog2(MAX_BYTES+1)-1:0] num_bytes,
    input  logic [7:0]                     wr_data,
    output logic [8*MAX_BYTES-1:0]         buffer,
    output logic                           done,
    output logic                           busy,
    output logic                           spi_cs_n,
    output logic                           spi_sclk,
    output logic                           spi_mosi,
    input  logic                           spi_miso
);

    localparam int LEN_W  = $clog2(MAX_BYTES + 1);
    localparam int BYTE_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    spi_state_t             state_q, state_d;
    logic                   rw_q, rw_d;
    logic [7:0]             wr_q, wr_d;
    logic [BYTE_W-1:0]      last_q, last_d;
    logic [7:0]             sh_q, sh_d;
    logic [6:0]             rx_q, rx_d;
    logic [2:0]             bit_q, bit_d;
    logic [BYTE_W-1:0]      byte_q, byte_d;
    logic                   mosi_q, mosi_d;
    logic [8*MAX_BYTES-1:0] buffer_q, buffer_d;

    logic [BYTE_W-1:0] eff_last;
    logic [7:0]        cmd_byte;
    logic [7:0]        data_first;
    logic              clk_en, allow_fall, last_bit;
    logic              rise_tick, fall_tick;

    // Index of the final byte: 0 requests one byte, oversize requests clamp
    always_comb begin
        if (num_bytes <= LEN_W'(1)) begin
            eff_last = '0;
        end else if (num_bytes >= LEN_W'(MAX_BYTES)) begin
            eff_last = BYTE_W'(MAX_BYTES - 1);
        end else begin
            eff_last = BYTE_W'(num_bytes - LEN_W'(1));
        end
    end

    always_comb begin
        cmd_byte             = '0;
        cmd_byte[CMD_RW]     = rw;
        cmd_byte[CMD_MB]     = rw && (eff_last != '0);
        cmd_byte[ADDR_W-1:0] = start_addr;
    end

    // Reads keep MOSI high through the data phase
    assign data_first = rw_q ? 8'hFF : wr_q;
    assign last_bit   = (bit_q == 3'd7) && (byte_q == last_q);
    assign clk_en     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    // SCLK must stay high after the last data bit so HOLD sees an idle clock
    assign allow_fall = (state_q == ST_SETUP) || (state_q == ST_CMD) ||
                        ((state_q == ST_DATA) && !last_bit);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .reset      (reset),
        .en         (clk_en),
        .allow_fall (allow_fall),
        .sclk       (spi_sclk),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick)
    );

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        wr_d     = wr_q;
        last_d   = last_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        mosi_d   = mosi_q;
        buffer_d = buffer_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    wr_d    = wr_data;
                    last_d  = rw ? eff_last : '0;
                    sh_d    = cmd_byte;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (fall_tick) begin
                    mosi_d  = sh_q[7];
                    sh_d    = {sh_q[6:0], 1'b1};
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (fall_tick) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        mosi_d  = data_first[7];
                        sh_d    = {data_first[6:0], 1'b1};
                        byte_d  = '0;
                        state_d = ST_DATA;
                    end else begin
                        mosi_d = sh_q[7];
                        sh_d   = {sh_q[6:0], 1'b1};
                    end
                end
            end
            ST_DATA: begin
                if (rise_tick && rw_q) begin
                    rx_d = {rx_q[5:0], spi_miso};
                    if (bit_q == 3'd7) begin
                        for (int k = 0; k < MAX_BYTES; k++) begin
                            if (byte_q == BYTE_W'(k)) begin
                                buffer_d[8*k +: 8] = {rx_q, spi_miso};
                            end
                        end
                    end
                end
                if (fall_tick) begin
                    bit_d = bit_q + 3'd1;
                    if (last_bit) begin
                        mosi_d  = MOSI_IDLE;
                        state_d = ST_HOLD;
                    end else begin
                        if (bit_q == 3'd7) begin
                            byte_d = byte_q + 1'b1;
                        end
                        mosi_d = sh_q[7];
                        sh_d   = {sh_q[6:0], 1'b1};
                    end
                end
            end
            ST_HOLD: begin
                if (fall_tick) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b0;
            wr_q     <= '0;
            last_q   <= '0;
            sh_q     <= 8'hFF;
            rx_q     <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            mosi_q   <= MOSI_IDLE;
            buffer_q <= '0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            wr_q     <= wr_d;
            last_q   <= last_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            mosi_q   <= mosi_d;
            buffer_q <= buffer_d;
        end
    end

    assign buffer   = buffer_q;
    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);
    assign spi_cs_n = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign spi_mosi = mosi_q;

endmodule

// File: doc/spi_burst_master.md
Name: spi_burst_master

Overview:
- Parametrised successor to the fixed single-shot SPI register reader.
- Owns the SPI bus: generates SCLK and CS, sends a command byte, then either reads a burst of 1..MAX_BYTES registers or writes one register.
- Sits between the accelerometer sample scheduler and the external SPI sensor (mode 3, 6-bit register address).
- Delivers the burst in a packed buffer with a one-cycle done pulse.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range is 2 or more.
- MAX_BYTES, 6: maximum data bytes per burst; sets the buffer width.
- ADDR_W, 6: register address width; the command byte is {rw, mb, addr}, which requires ADDR_W = 6.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- rw  in  1  1 = burst read, 0 = single-byte write.
- start_addr  in  ADDR_W  first register address.
- num_bytes  in  $clog2(MAX_BYTES+1)  read length.
- wr_data  in  8  write payload, used when rw=0.
- buffer  out  8*MAX_BYTES  read data; byte k is at [8k+7:8k].
- done  out  1  one-cycle pulse when the transaction completes.
- busy  out  1  high from the start accept through done, inclusive.
- spi_cs_n  out  1  chip select, active low.
- spi_sclk  out  1  SPI clock; idles high.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.

Behaviour:
- Reset values: buffer=0, done=0, busy=0, spi_cs_n=1, spi_sclk=1, spi_mosi=1, state=IDLE.
- Reset asserted mid-transaction aborts immediately: CS released, SCLK high, buffer cleared.
- States: IDLE -> SETUP -> CMD -> DATA -> HOLD -> DONE -> IDLE.
- IDLE:
  - start=1 latches rw, start_addr, wr_data and the effective length.
  - Effective length: num_bytes=0 is treated as 1; values above MAX_BYTES clamp to MAX_BYTES.
  - Asserts busy and drives spi_cs_n low; next state is SETUP.
- SETUP: waits CLK_DIV clocks (CS-to-first-edge setup time), then goes to CMD.
- CMD: shifts out the command byte MSB-first.
  - bit7 = rw; bit6 = mb, which is 1 when a read has effective length > 1 and is 0 for writes.
  - bits5:0 = start_addr.
- SPI timing, mode 3:
  - spi_sclk toggles every CLK_DIV clocks.
  - spi_mosi updates on each falling edge.
  - spi_miso is sampled on the clock in which spi_sclk is driven rising.
- DATA:
  - rw=1: shift in 8*N bits MSB-first; data byte k is written to buffer[8k+7:8k] when its 8th bit is sampled.
  - rw=0: shift out wr_data MSB-first for 8 bits; buffer is unchanged.
- HOLD: SCLK is high; wait CLK_DIV clocks, then raise spi_cs_n.
- DONE: assert done for exactly one clock; busy drops on the following clock.
- Buffer retention:
  - Bytes at index N and above are not modified during a read.
  - Buffer holds its value until the next read overwrites it.
- Timing and handshake:
  - Latency from start accept to done is 2*CLK_DIV + 16*CLK_DIV*(1+N) + 1 clocks, where N=1 for writes.
  - start while busy is ignored and does not queue.
  - spi_mosi is driven to 1 outside CMD/DATA.
- Internal counters:
  - bit counter: 3 bits.
  - byte counter: $clog2(MAX_BYTES) bits.
  - divider: $clog2(CLK_DIV) bits.
  - All counters wrap only under state control, never free-running.

Decomposition:
- Shared package spi_pkg holds:
  - state enum;
  - command-bit positions (CMD_RW=7, CMD_MB=6);
  - SPI mode constants.
- One sub-module is natural: spi_clk_gen (divider), outputting sclk, rise_tick, fall_tick, enabled only outside IDLE/DONE.
- Shift and framing logic stays in spi_burst_master.

Test Plan:
- Reset behaviour: reset low mid-DATA (CLK_DIV=4, N=6 read) -> within 0 clocks spi_cs_n=1, spi_sclk=1, busy=0, buffer=0; after release, the next start runs normally.
- Burst read: rw=1, start_addr=0x32, num_bytes=6; the MISO model returns 0x11..0x66.
  - MOSI command byte is 0xF2.
  - buffer = 0x665544332211.
  - done is high 1 clock at 2*4+16*4*7+1 = 457 clocks after start.
- Single read: rw=1, start_addr=0x00, num_bytes=1; MISO model returns 0xE5.
  - Command byte is 0x80 (mb=0).
  - buffer[7:0] = 0xE5; upper buffer bytes are unchanged from the previous test.
- Write: rw=0, start_addr=0x2D, wr_data=0x08.
  - MOSI stream is 0x2D then 0x08; buffer is unchanged.
  - Exactly 16 rising SCLK edges while spi_cs_n=0.
- Length boundaries:
  - num_bytes=0 -> exactly 16 SCLK edges total, with 8 data bits.
  - num_bytes=7 (above MAX_BYTES) -> clamped to 6 bytes, 56 edges total.
  - start pulsed while busy -> ignored: no second transaction, done pulses once.
